// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared warp scheduling types and constants
package gpu_pkg;
    localparam int WARP_SIZE_DEFAULT = 32;
    localparam int WARP_SIZE_LOG2    = $clog2(WARP_SIZE_DEFAULT);
    localparam int MAX_WARPS         = 255;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        DRAIN,
        DONE
    } warp_sched_state_t;

    // Mask is sized for the largest legal warp; narrower warps use the low bits.
    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] base_thread;
        logic [31:0] active_mask;
    } warp_desc_t;
endpackage

// File: rtl/warp_scheduler_if.sv
// rtl/warp_scheduler_if.sv - warp issue handshake and retire channel
// master: scheduler side (drives descriptor, samples ready and retire)
// slave:  execution pipeline side (samples descriptor, drives ready and retire)
interface warp_scheduler_if
    import gpu_pkg::*;
#(
    parameter int WARP_SIZE = WARP_SIZE_DEFAULT
) ();
    logic                 warp_valid;
    logic                 warp_ready;
    logic [7:0]           warp_id;
    logic [31:0]          warp_base_thread;
    logic [WARP_SIZE-1:0] warp_active_mask;
    logic                 warp_retire;

    modport master (
        output warp_valid,
        output warp_id,
        output warp_base_thread,
        output warp_active_mask,
        input  warp_ready,
        input  warp_retire
    );

    modport slave (
        input  warp_valid,
        input  warp_id,
        input  warp_base_thread,
        input  warp_active_mask,
        output warp_ready,
        output warp_retire
    );
endinterface

// File: rtl/warp_mask_gen.sv
// rtl/warp_mask_gen.sv - lane-active mask for one warp of a block
// Ports: warp_id (warp index in block), tib (threads in block) -> active_mask
//   bit n is set when warp_id*WARP_SIZE + n < tib.
module warp_mask_gen
    import gpu_pkg::*;
#(
    parameter int WARP_SIZE = WARP_SIZE_DEFAULT
) (
    input  logic [7:0]           warp_id,
    input  logic [31:0]          tib,
    output logic [WARP_SIZE-1:0] active_mask
);
    localparam int LOG2 = $clog2(WARP_SIZE);

    // 33 bits so the lane index can never wrap before the compare.
    logic [32:0] first_lane;

    always_comb begin
        active_mask = '0;
        first_lane  = {25'd0, warp_id} << LOG2;
        for (int n = 0; n < WARP_SIZE; n++) begin
            active_mask[n] = (first_lane + 33'(n)) < {1'b0, tib};
        end
    end
endmodule

// File: rtl/warp_scheduler.sv
// rtl/warp_scheduler.sv - splits a thread block into warps and issues them
// Ports: clk, rst (async, active high)
//   core_start, block_id, num_threads, block_dim: block request from the dispatcher
//   wif (master): warp descriptor valid/ready issue plus warp_retire pulses
//   core_done: one-cycle pulse once every warp has issued and retired
//   busy: high in every state except IDLE
module warp_scheduler
    import gpu_pkg::*;
#(
    parameter int WARP_SIZE    = WARP_SIZE_DEFAULT,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             core_start,
    input  logic [31:0]      block_id,
    input  logic [31:0]      num_threads,
    input  logic [31:0]      block_dim,
    warp_scheduler_if.master wif,
    output logic             core_done,
    output logic             busy
);
    localparam int          LOG2           = $clog2(WARP_SIZE);
    localparam logic [31:0] WARP_STEP      = 32'(WARP_SIZE);
    localparam logic [31:0] LANE_MASK      = WARP_STEP - 32'd1;
    localparam logic [7:0]  MAX_INFLIGHT_C = 8'(MAX_INFLIGHT);

    warp_sched_state_t state_q, state_d;
    logic [31:0] block_id_q, block_id_d;
    logic [31:0] num_threads_q, num_threads_d;
    logic [31:0] block_dim_q, block_dim_d;
    logic [31:0] base_q, base_d;
    logic [31:0] tib_q, tib_d;
    logic [7:0]  nwarps_q, nwarps_d;
    logic [7:0]  inflight_q, inflight_d;
    logic [7:0]  retired_q, retired_d;
    warp_desc_t  desc_q, desc_d;
    logic        warp_valid_q, warp_valid_d;
    logic        core_done_q, core_done_d;
    logic        busy_q, busy_d;

    logic [31:0]          setup_base;
    logic [31:0]          setup_remaining;
    logic [31:0]          setup_tib;
    logic [32:0]          setup_nwarps_full;
    logic [7:0]           setup_nwarps;
    logic                 setup_sat;
    logic                 handshake;
    logic                 retire_eff;
    logic [7:0]           next_id;
    logic [31:0]          next_base;
    logic [WARP_SIZE-1:0] next_mask;

    // The mask is generated for the descriptor about to be registered, so
    // the output mask is a flop and holds steady under backpressure.
    warp_mask_gen #(.WARP_SIZE(WARP_SIZE)) u_mask_gen (
        .warp_id     (next_id),
        .tib         (tib_d),
        .active_mask (next_mask)
    );

    assign desc_d = {next_id, next_base, 32'(next_mask)};

    // Block geometry, evaluated from the latched request during SETUP.
    always_comb begin
        setup_base      = block_id_q * block_dim_q;
        setup_remaining = num_threads_q - setup_base;
        setup_tib       = '0;
        if (setup_base < num_threads_q) begin
            setup_tib = (block_dim_q < setup_remaining) ? block_dim_q : setup_remaining;
        end
        setup_nwarps_full = 33'(setup_tib >> LOG2) + 33'(|(setup_tib & LANE_MASK));
        setup_sat         = setup_nwarps_full > 33'(MAX_WARPS);
        setup_nwarps      = setup_sat ? 8'(MAX_WARPS) : setup_nwarps_full[7:0];
    end

    always_comb begin
        state_d       = state_q;
        block_id_d    = block_id_q;
        num_threads_d = num_threads_q;
        block_dim_d   = block_dim_q;
        base_d        = base_q;
        tib_d         = tib_q;
        nwarps_d      = nwarps_q;
        next_id       = desc_q.id;
        next_base     = desc_q.base_thread;

        handshake  = warp_valid_q && wif.warp_ready;
        // A retire with nothing in flight is dropped so the count cannot underflow.
        retire_eff = wif.warp_retire && (inflight_q != 8'd0);
        inflight_d = inflight_q + 8'(handshake) - 8'(retire_eff);
        retired_d  = retired_q + 8'(retire_eff);

        unique case (state_q)
            IDLE: begin
                if (core_start) begin
                    block_id_d    = block_id;
                    num_threads_d = num_threads;
                    block_dim_d   = block_dim;
                    state_d       = SETUP;
                end
            end
            SETUP: begin
                base_d    = setup_base;
                tib_d     = setup_tib;
                nwarps_d  = setup_nwarps;
                next_id   = 8'd0;
                next_base = setup_base;
                retired_d = 8'd0;
                state_d   = (setup_nwarps == 8'd0) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (handshake) begin
                    next_id   = desc_q.id + 8'd1;
                    next_base = desc_q.base_thread + WARP_STEP;
                    // 9-bit compare so a 255-warp block terminates cleanly.
                    if (({1'b0, desc_q.id} + 9'd1) == {1'b0, nwarps_q}) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (retired_d == nwarps_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        warp_valid_d = (state_d == ISSUE) && (inflight_d < MAX_INFLIGHT_C);
        core_done_d  = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            block_id_q    <= '0;
            num_threads_q <= '0;
            block_dim_q   <= '0;
            base_q        <= '0;
            tib_q         <= '0;
            nwarps_q      <= '0;
            inflight_q    <= '0;
            retired_q     <= '0;
            desc_q        <= '0;
            warp_valid_q  <= 1'b0;
            core_done_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            block_id_q    <= block_id_d;
            num_threads_q <= num_threads_d;
            block_dim_q   <= block_dim_d;
            base_q        <= base_d;
            tib_q         <= tib_d;
            nwarps_q      <= nwarps_d;
            inflight_q    <= inflight_d;
            retired_q     <= retired_d;
            desc_q        <= desc_d;
            warp_valid_q  <= warp_valid_d;
            core_done_q   <= core_done_d;
            busy_q        <= busy_d;
        end
    end

    assign wif.warp_valid       = warp_valid_q;
    assign wif.warp_id          = desc_q.id;
    assign wif.warp_base_thread = desc_q.base_thread;
    assign wif.warp_active_mask = desc_q.active_mask[WARP_SIZE-1:0];
    assign core_done            = core_done_q;
    assign busy                 = busy_q;

    nwarps_fit_a: assert property (@(posedge clk) disable iff (rst)
        (state_q == SETUP) |-> !setup_sat);

    retire_needs_inflight_a: assert property (@(posedge clk) disable iff (rst)
        wif.warp_retire |-> (inflight_q != 8'd0))
        else $warning("warp_retire with no warp in flight was ignored");
endmodule

// File: tb/tb_warp_scheduler.sv
// tb/tb_warp_scheduler.sv - self-checking bench for warp_scheduler
module tb_warp_scheduler;
    import gpu_pkg::*;

    localparam int WS   = 32;
    localparam int MAXI = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_start = 1'b0;
    logic [31:0] block_id = '0;
    logic [31:0] num_threads = '0;
    logic [31:0] block_dim = '0;
    logic        core_done;
    logic        busy;

    warp_scheduler_if #(.WARP_SIZE(WS)) wif ();

    warp_scheduler #(.WARP_SIZE(WS), .MAX_INFLIGHT(MAXI)) dut (
        .clk         (clk),
        .rst         (rst),
        .core_start  (core_start),
        .block_id    (block_id),
        .num_threads (num_threads),
        .block_dim   (block_dim),
        .wif         (wif),
        .core_done   (core_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: a block is a list of warps; track how many issued,
    // how many retired, and how many are outstanding.
    int     m_busy = 0, m_setup = 0, m_done = 0;
    int     m_nw = 0, m_issued = 0, m_retired = 0, m_inflight = 0;
    longint m_base = 0, m_tib = 0;

    function automatic longint base_of(logic [31:0] id, logic [31:0] dim);
        return (longint'(id) * longint'(dim)) & 64'hFFFF_FFFF;
    endfunction

    function automatic longint tib_of(logic [31:0] id, logic [31:0] dim, logic [31:0] nt);
        longint b = base_of(id, dim);
        longint rem;
        if (b >= longint'(nt)) return 0;
        rem = longint'(nt) - b;
        return (longint'(dim) < rem) ? longint'(dim) : rem;
    endfunction

    function automatic int calc_nw(longint tib);
        longint n = (tib + WS - 1) / WS;
        return (n > 255) ? 255 : int'(n);
    endfunction

    function automatic bit exp_valid_f();
        return (m_busy != 0) && (m_setup == 0) && (m_issued < m_nw) && (m_inflight < MAXI);
    endfunction

    function automatic logic [31:0] exp_mask_f(int w);
        logic [31:0] m = '0;
        for (int n = 0; n < WS; n++) m[n] = (longint'(w) * WS + n) < m_tib;
        return m;
    endfunction

    function automatic int model_hs();
        return (exp_valid_f() && wif.warp_ready === 1'b1) ? 1 : 0;
    endfunction

    function automatic int model_rt();
        return (wif.warp_retire === 1'b1 && m_inflight > 0) ? 1 : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0; m_setup <= 0; m_done <= 0; m_nw <= 0;
            m_issued <= 0; m_retired <= 0; m_inflight <= 0; m_base <= 0; m_tib <= 0;
        end else if (m_done != 0) begin
            m_done <= 0;
        end else if (m_busy == 0) begin
            if (core_start) begin
                m_busy     <= 1;
                m_setup    <= 1;
                m_base     <= base_of(block_id, block_dim);
                m_tib      <= tib_of(block_id, block_dim, num_threads);
                m_nw       <= calc_nw(tib_of(block_id, block_dim, num_threads));
                m_issued   <= 0;
                m_retired  <= 0;
                m_inflight <= 0;
            end
        end else if (m_setup != 0) begin
            m_setup <= 0;
            if (m_nw == 0) begin
                m_busy <= 0;
                m_done <= 1;
            end
        end else begin
            m_inflight <= m_inflight + model_hs() - model_rt();
            m_issued   <= m_issued + model_hs();
            m_retired  <= m_retired + model_rt();
            if (m_retired + model_rt() == m_nw) begin
                m_busy <= 0;
                m_done <= 1;
            end
        end
    end

    // Per-cycle comparison against the model, plus a log of accepted descriptors.
    int          done_pulses = 0;
    logic [31:0] hs_base[$];
    logic [31:0] hs_mask[$];
    int          hs_id[$];

    always @(negedge clk) begin
        check("warp_valid", wif.warp_valid, exp_valid_f());
        check("busy", busy, (m_busy != 0 || m_done != 0));
        check("core_done", core_done, (m_done != 0));
        if (exp_valid_f()) begin
            check("warp_id", wif.warp_id, m_issued);
            check("warp_base_thread", wif.warp_base_thread, (m_base + longint'(m_issued) * WS) & 64'hFFFF_FFFF);
            check("warp_active_mask", wif.warp_active_mask, exp_mask_f(m_issued));
        end
        if (core_done === 1'b1) done_pulses++;
        if (wif.warp_valid === 1'b1 && wif.warp_ready === 1'b1) begin
            hs_base.push_back(wif.warp_base_thread);
            hs_mask.push_back(wif.warp_active_mask);
            hs_id.push_back(int'(wif.warp_id));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_block(input logic [31:0] id, input logic [31:0] dim, input logic [31:0] nt);
        block_id    = id;
        block_dim   = dim;
        num_threads = nt;
        core_start  = 1'b1;
    endtask

    task automatic clear_log();
        hs_base.delete();
        hs_mask.delete();
        hs_id.delete();
    endtask

    // Runs the pipeline side until the model reports completion.
    task automatic run_block(input int ready_pct, input int retire_pct, input int max_cycles, input bit scramble);
        bit finished = 0;
        for (int c = 0; c < max_cycles; c++) begin
            tick();
            if (m_done != 0) begin
                finished = 1;
                break;
            end
            wif.warp_ready  = ($urandom_range(99) < ready_pct);
            wif.warp_retire = (m_inflight > 0) && ($urandom_range(99) < retire_pct);
            if (scramble && m_busy != 0) begin
                block_id    = $urandom;
                num_threads = $urandom;
                block_dim   = $urandom;
            end
        end
        core_start      = 1'b0;
        wif.warp_ready  = 1'b0;
        wif.warp_retire = 1'b0;
        check("block_completed", finished, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        wif.warp_ready  = 1'b0;
        wif.warp_retire = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_valid", wif.warp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_core_done", core_done, 0);
        check("rst_warp_id", wif.warp_id, 0);
        check("rst_base", wif.warp_base_thread, 0);
        check("rst_mask", wif.warp_active_mask, 0);
        rst = 1'b0;
        tick();

        // Partial last warp: tib = 36, two warps.
        clear_log();
        d0 = done_pulses;
        start_block(1, 64, 100);
        wif.warp_ready = 1'b1;
        tick();
        check("t1_setup_valid", wif.warp_valid, 0);
        check("t1_setup_busy", busy, 1);
        tick();
        check("t1_first_valid", wif.warp_valid, 1);
        run_block(100, 100, 200, 0);
        tick(); tick();
        check("t1_warps", hs_base.size(), 2);
        if (hs_base.size() == 2) begin
            check("t1_w0_base", hs_base[0], 32'd64);
            check("t1_w0_mask", hs_mask[0], 32'hFFFF_FFFF);
            check("t1_w1_base", hs_base[1], 32'd96);
            check("t1_w1_mask", hs_mask[1], 32'h0000_000F);
        end
        check("t1_done_pulses", done_pulses - d0, 1);

        // Empty block: base 128 is past num_threads.
        clear_log();
        start_block(2, 64, 100);
        tick();
        check("t2_setup_busy", busy, 1);
        check("t2_setup_done", core_done, 0);
        tick();
        check("t2_core_done", core_done, 1);
        check("t2_valid", wif.warp_valid, 0);
        core_start = 1'b0;
        tick();
        check("t2_done_drop", core_done, 0);
        check("t2_idle", busy, 0);
        check("t2_no_warps", hs_base.size(), 0);

        // Backpressure: descriptor holds while ready is low.
        clear_log();
        start_block(0, 64, 1000);
        wif.warp_ready = 1'b0;
        tick();
        tick();
        check("t3_valid", wif.warp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_valid", wif.warp_valid, 1);
            check("t3_hold_id", wif.warp_id, 0);
            check("t3_hold_base", wif.warp_base_thread, 0);
            check("t3_hold_mask", wif.warp_active_mask, 32'hFFFF_FFFF);
        end
        run_block(100, 100, 200, 0);
        check("t3_warps", hs_base.size(), 2);
        if (hs_base.size() == 2) check("t3_w1_base", hs_base[1], 32'd32);
        tick();

        // Throttle at MAXI in flight, then retire and simultaneous issue+retire.
        clear_log();
        start_block(0, 128, 1000);
        wif.warp_ready  = 1'b1;
        wif.warp_retire = 1'b0;
        repeat (8) tick();
        check("t4_throttled_count", hs_base.size(), 2);
        check("t4_throttled_valid", wif.warp_valid, 0);
        check("t4_throttled_busy", busy, 1);
        wif.warp_retire = 1'b1;
        tick();
        check("t4_release_valid", wif.warp_valid, 1);
        check("t4_release_id", wif.warp_id, 2);
        wif.warp_retire = 1'b1;
        tick();
        wif.warp_retire = 1'b0;
        check("t4_same_edge_count", hs_id.size(), 3);
        check("t4_same_edge_valid", wif.warp_valid, 1);
        check("t4_same_edge_id", wif.warp_id, 3);
        run_block(100, 100, 200, 0);
        check("t4_total_warps", hs_id.size(), 4);
        tick();

        // Spurious retire while idle.
        wif.warp_retire = 1'b1;
        tick();
        wif.warp_retire = 1'b0;
        tick();
        check("t5_idle_busy", busy, 0);
        check("t5_idle_valid", wif.warp_valid, 0);
        check("t5_idle_done", core_done, 0);

        // Asynchronous reset after one warp has issued.
        clear_log();
        start_block(0, 128, 1000);
        wif.warp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_issued >= 1) break;
        end
        wif.warp_ready = 1'b0;
        check("t6_one_issued", hs_id.size(), 1);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_valid", wif.warp_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", core_done, 0);
        check("t6_rst_id", wif.warp_id, 0);
        check("t6_rst_base", wif.warp_base_thread, 0);
        check("t6_rst_mask", wif.warp_active_mask, 0);
        core_start = 1'b0;
        tick(); tick();
        rst = 1'b0;
        d0 = done_pulses;
        repeat (3) tick();
        check("t6_no_done", done_pulses - d0, 0);
        clear_log();
        start_block(0, 128, 1000);
        run_block(100, 100, 200, 0);
        check("t6_restart_count", hs_id.size(), 4);
        if (hs_id.size() > 0) check("t6_restart_id0", hs_id[0], 0);

        // Randomized blocks, back to back, with request fields scrambled mid-block.
        for (int b = 0; b < 40; b++) begin
            start_block($urandom_range(7), $urandom_range(200, 1), $urandom_range(1000));
            run_block($urandom_range(100, 30), $urandom_range(90, 20), 3000, 1);
        end
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
Per-core stage directly downstream of the block dispatcher. It accepts one thread block (core_start plus block_id), splits it into warps of WARP_SIZE threads, and issues each warp with its base global thread index and lane-active mask over a valid/ready handshake to the core's execution pipeline. It tracks in-flight warps, counts retirements, and pulses core_done when every warp of the block has issued and retired.

Parameters:
WARP_SIZE, 32, threads per warp; must be a power of two, 2..32.
MAX_INFLIGHT, 4, maximum issued-but-unretired warps; 1..255.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
core_start  in  1  level from dispatcher; a block is pending when high
block_id  in  32  block index; valid while core_start is high
num_threads  in  32  kernel total thread count
block_dim  in  32  kernel threads per block
warp_valid  out  1  warp descriptor valid
warp_ready  in  1  execution pipeline accepts the descriptor
warp_id  out  8  warp index within the block
warp_base_thread  out  32  global thread index of lane 0
warp_active_mask  out  WARP_SIZE  bit n set when lane n maps to a real thread
warp_retire  in  1  one-cycle pulse per completed warp
core_done  out  1  one-cycle pulse when the block is complete
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state): state IDLE. warp_valid, warp_id, warp_base_thread, warp_active_mask, core_done, busy, in-flight count, and issued count all go to 0.
- States: IDLE, SETUP, ISSUE, DRAIN, DONE.
- IDLE: on an edge with core_start=1, latch block_id, num_threads, and block_dim, then go to SETUP.
- SETUP (1 cycle): compute and register the following.
  - base = block_id*block_dim, truncated to 32 bits.
  - tib = (base >= num_threads) ? 0 : min(block_dim, num_threads-base).
  - nwarps = ceil(tib/WARP_SIZE), using a shift and add.
  - If nwarps = 0, go to DONE. Otherwise go to ISSUE with warp_id=0.
  - nwarps > 255 is saturated to 255 and flagged by a simulation-only assertion.
- ISSUE: warp_valid is high whenever inflight < MAX_INFLIGHT.
  - warp_valid first rises 2 cycles after core_start is sampled.
  - Descriptor: warp_base_thread = base + warp_id*WARP_SIZE. warp_active_mask bit n = (warp_id*WARP_SIZE + n < tib).
  - Descriptor fields are registered and must not change while warp_valid=1 and warp_ready=0.
  - On a handshake (valid & ready): inflight+1 and warp_id+1. After the last warp issues, go to DRAIN the next cycle.
- In-flight count:
  - Handshake and warp_retire on the same edge leave the count unchanged.
  - warp_retire with count 0 is ignored and raises a sim assertion.
  - At inflight = MAX_INFLIGHT, warp_valid is deasserted until a retire occurs.
- DRAIN: warp_valid=0. When the retire count equals nwarps (including a retire on the current edge), go to DONE.
- DONE (1 cycle): core_done=1, then return to IDLE.
  - The dispatcher drops core_start on the same edge, so the block is not re-accepted.
  - A new block can be accepted on the second edge after DONE.
- core_start is ignored outside IDLE. block_id changes outside IDLE have no effect.
- Reset mid-block discards all state. No core_done is produced for the aborted block.

Decomposition:
- Shared package gpu_pkg holds:
  - WARP_SIZE default and its log2 constant.
  - warp_sched_state_t enum (IDLE/SETUP/ISSUE/DRAIN/DONE).
  - the warp descriptor struct (id, base_thread, active_mask).
- One combinational sub-module, warp_mask_gen, maps (warp_id, tib) to the active mask. Everything else stays in warp_scheduler.

Test Plan:
- Partial last warp (WARP_SIZE=32, num_threads=100, block_dim=64, block_id=1). Expect tib=36, two warps:
  - warp0: base 64, mask 0xFFFFFFFF.
  - warp1: base 96, mask 0x0000000F.
  - After two retires, core_done pulses exactly once.
- Empty block (block_id=2, block_dim=64, num_threads=100). Expect no warp_valid, and core_done high 2 cycles after core_start is sampled.
- Backpressure: hold warp_ready=0 for 5 cycles during ISSUE. warp_valid stays high with all descriptor fields stable; issue resumes on ready.
- Throttle (MAX_INFLIGHT=2, block_dim=128, full block, no retires). Exactly 2 warps issue, then warp_valid=0; one warp_retire lets warp 2 issue on the next cycle.
- Simultaneous handshake and retire on the same edge leaves inflight unchanged. A spurious retire in IDLE changes nothing.
- Assert rst asynchronously in ISSUE after 1 warp. All outputs are 0 immediately, with no core_done; a fresh core_start then restarts at warp_id 0.
